// File: rtl/rvvi_depacketizer.sv
// Receive-side RVVI depacketizer: filters Ethernet frames on destination MAC and ethertype,
// strips the header and reassembles the little-endian payload into one RVVI record.
module rvvi_depacketizer #(
    parameter int          XLEN       = 64,
    parameter int          MAX_CSRS   = 5,
    parameter logic [15:0] ETHER_TYPE = 16'h005c,
    parameter logic [47:0] LOCAL_MAC  = 48'h1654_1111_6843,
    localparam int         RVVI_W     = 72 + 5 * XLEN + MAX_CSRS * (XLEN + 16)
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic [31:0]       RvviAxiRdata,
    input  logic [3:0]        RvviAxiRstrb,
    input  logic              RvviAxiRvalid,
    input  logic              RvviAxiRlast,
    input  logic              RvviAxiRuser,
    output logic              RvviAxiRready,
    output logic [RVVI_W-1:0] rvvi,
    output logic              valid,
    input  logic              ready,
    output logic [15:0]       SeqNum,
    output logic              SeqError,
    output logic [31:0]       FrameCount,
    output logic [31:0]       DropCount
);

    localparam int PAYLOAD_WORDS = (RVVI_W + 31) / 32;
    localparam int LAST_BITS     = RVVI_W - (PAYLOAD_WORDS - 1) * 32;
    localparam int LAST_BYTES    = (LAST_BITS + 7) / 8;
    localparam int IDX_W         = (PAYLOAD_WORDS > 4) ? $clog2(PAYLOAD_WORDS) : 2;

    // Bytes of the final payload beat that carry record bits; the rest may be absent.
    localparam logic [3:0]       LAST_KEEP = 4'((1 << LAST_BYTES) - 1);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {HDR, PAY, DROP, HOLD} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               rx_ready;
    logic               dst_lo_local;
    logic               dst_lo_bcast;
    logic [15:0]        seq_tag;
    logic [15:0]        seq_expect;
    logic               first_frame;
    logic [31:0]        pay_buf [PAYLOAD_WORDS-1];
    logic [RVVI_W-1:0]  record_next;
    logic               beat;
    logic               full_word;
    logic               dst_hi_ok;
    logic               hdr_bad;

    assign RvviAxiRready = rx_ready;
    assign beat          = RvviAxiRvalid & rx_ready;
    assign full_word     = (RvviAxiRstrb == 4'hF);
    assign dst_hi_ok     = (dst_lo_local && RvviAxiRdata[15:0] == LOCAL_MAC[47:32]) ||
                           (dst_lo_bcast && RvviAxiRdata[15:0] == 16'hFFFF);
    assign hdr_bad       = !full_word ||
                           (idx == IDX_W'(1) && !dst_hi_ok) ||
                           (idx == IDX_W'(3) && RvviAxiRdata[15:0] != ETHER_TYPE);

    // The final beat goes straight into the record; earlier beats come from the buffer.
    always_comb begin
        // NOTE: default assignment first so every path drives record_next and no latch is inferred.
        record_next = '0;
        for (int i = 0; i < PAYLOAD_WORDS - 1; i++) begin
            record_next[i*32 +: 32] = pay_buf[i];
        end
        record_next[RVVI_W-1 -: LAST_BITS] = RvviAxiRdata[LAST_BITS-1:0];
    end

    // NOTE: the payload buffer has no reset; every slot is rewritten before a record is built from it.
    always_ff @(posedge m_axi_aclk) begin
        if (beat && state == PAY && idx != LAST_SLOT) begin
            pay_buf[idx] <= RvviAxiRdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state        <= HDR;
            idx          <= '0;
            rx_ready     <= 1'b0;
            dst_lo_local <= 1'b0;
            dst_lo_bcast <= 1'b0;
            seq_tag      <= '0;
            seq_expect   <= '0;
            first_frame  <= 1'b1;
            rvvi         <= '0;
            valid        <= 1'b0;
            SeqNum       <= '0;
            SeqError     <= 1'b0;
            FrameCount   <= '0;
            DropCount    <= '0;
        end else begin
            SeqError <= 1'b0;
            case (state)
                HDR: begin
                    rx_ready <= 1'b1;
                    if (beat) begin
                        if (idx == IDX_W'(0)) begin
                            dst_lo_local <= (RvviAxiRdata == LOCAL_MAC[31:0]);
                            dst_lo_bcast <= (RvviAxiRdata == 32'hFFFF_FFFF);
                        end
                        if (idx == IDX_W'(3)) seq_tag <= RvviAxiRdata[31:16];
                        if (RvviAxiRlast) begin
                            idx       <= '0;
                            DropCount <= DropCount + 32'd1;
                        end else if (hdr_bad) begin
                            state     <= DROP;
                            idx       <= '0;
                            DropCount <= DropCount + 32'd1;
                        end else if (idx == IDX_W'(3)) begin
                            state <= PAY;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PAY: begin
                    if (beat) begin
                        if (idx == LAST_SLOT) begin
                            idx <= '0;
                            if (!RvviAxiRlast) begin
                                state     <= DROP;
                                DropCount <= DropCount + 32'd1;
                            end else if (!RvviAxiRuser && (RvviAxiRstrb & LAST_KEEP) == LAST_KEEP) begin
                                state       <= HOLD;
                                rx_ready    <= 1'b0;
                                valid       <= 1'b1;
                                rvvi        <= record_next;
                                SeqNum      <= seq_tag;
                                SeqError    <= !first_frame && (seq_tag != seq_expect);
                                seq_expect  <= seq_tag + 16'd1;
                                first_frame <= 1'b0;
                            end else begin
                                state     <= HDR;
                                DropCount <= DropCount + 32'd1;
                            end
                        end else if (RvviAxiRlast) begin
                            state     <= HDR;
                            idx       <= '0;
                            DropCount <= DropCount + 32'd1;
                        end else if (!full_word) begin
                            state     <= DROP;
                            idx       <= '0;
                            DropCount <= DropCount + 32'd1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (beat && RvviAxiRlast) state <= HDR;
                end
                HOLD: begin
                    if (ready) begin
                        valid      <= 1'b0;
                        FrameCount <= FrameCount + 32'd1;
                        state      <= HDR;
                        rx_ready   <= 1'b1;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer: drives Ethernet frames, scoreboards delivered records
// and checks filtering, drop counting, back-pressure, sequence checking and mid-frame reset.
module tb_rvvi_depacketizer;

    localparam int          XLEN      = 64;
    localparam int          MAX_CSRS  = 5;
    localparam int          RVVI_W    = 72 + 5 * XLEN + MAX_CSRS * (XLEN + 16);
    localparam int          PW        = (RVVI_W + 31) / 32;
    localparam logic [15:0] ETYPE     = 16'h005c;
    localparam logic [47:0] MAC       = 48'h1654_1111_6843;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam int          BUDGET    = 300;

    logic              clk;
    logic              rst_n;
    logic [31:0]       RvviAxiRdata;
    logic [3:0]        RvviAxiRstrb;
    logic              RvviAxiRvalid;
    logic              RvviAxiRlast;
    logic              RvviAxiRuser;
    logic              RvviAxiRready;
    logic [RVVI_W-1:0] rvvi;
    logic              valid;
    logic              ready;
    logic [15:0]       SeqNum;
    logic              SeqError;
    logic [31:0]       FrameCount;
    logic [31:0]       DropCount;

    typedef struct {
        logic [RVVI_W-1:0] rec;
        logic [15:0]       seq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    int   exp_drops = 0;

    rvvi_depacketizer dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .RvviAxiRdata  (RvviAxiRdata),
        .RvviAxiRstrb  (RvviAxiRstrb),
        .RvviAxiRvalid (RvviAxiRvalid),
        .RvviAxiRlast  (RvviAxiRlast),
        .RvviAxiRuser  (RvviAxiRuser),
        .RvviAxiRready (RvviAxiRready),
        .rvvi          (rvvi),
        .valid         (valid),
        .ready         (ready),
        .SeqNum        (SeqNum),
        .SeqError      (SeqError),
        .FrameCount    (FrameCount),
        .DropCount     (DropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input logic [RVVI_W-1:0] obs, input logic [RVVI_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pay_word(input int seed, input int j);
        logic [15:0] mix;
        mix = 16'(seed * 977 + j * 131) ^ 16'h5A3C;
        return {8'(seed), 8'(j), mix};
    endfunction

    // Expected record assembled bit by bit from the payload words.
    function automatic logic [RVVI_W-1:0] exp_record(input int seed);
        logic [RVVI_W-1:0] r;
        logic [31:0]       w;
        r = '0;
        for (int j = 0; j < PW; j++) begin
            w = pay_word(seed, j);
            for (int b = 0; b < 32; b++) begin
                if (j * 32 + b < RVVI_W) r[j*32+b] = w[b];
            end
        end
        return r;
    endfunction

    // Pops and compares every record the DUT hands over.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            check("record_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_rec("rvvi", rvvi, mon_e.rec);
                check("SeqNum", 32'(SeqNum), 32'(mon_e.seq));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_rx_ready"}, 32'(RvviAxiRready), 32'd0);
        check({tag, "_frames"}, FrameCount, 32'd0);
        check({tag, "_drops"}, DropCount, 32'd0);
        check({tag, "_seqnum"}, 32'(SeqNum), 32'd0);
        check({tag, "_seqerr"}, 32'(SeqError), 32'd0);
        check_rec({tag, "_rvvi"}, rvvi, '0);
    endtask

    // Presents one beat at a negedge and returns at the negedge after it was accepted.
    task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                             input logic user, output int waits);
        RvviAxiRdata  = data;
        RvviAxiRstrb  = strb;
        RvviAxiRlast  = last;
        RvviAxiRuser  = user;
        RvviAxiRvalid = 1'b1;
        waits = 0;
        while (RvviAxiRready !== 1'b1 && waits < BUDGET) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= BUDGET) check("rx_ready_timeout", 32'(RvviAxiRready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] seq,
                              input int seed, input int n_pay, input logic [3:0] last_strb,
                              input logic user, input int reset_at, input bit deliver,
                              output int stalls);
        logic [31:0] words[$];
        int          w;
        logic        last;
        words.push_back(dst[31:0]);
        words.push_back({16'h00AA, dst[47:32]});
        words.push_back(32'h0200_0000);
        words.push_back({seq, etype});
        for (int j = 0; j < n_pay; j++) words.push_back(pay_word(seed, j));
        if (deliver) sb.push_back('{exp_record(seed), seq});
        stalls = 0;
        for (int k = 0; k < words.size(); k++) begin
            if (k == reset_at) begin
                RvviAxiRvalid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_state("midframe_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
            last = (k == words.size() - 1);
            send_beat(words[k], last ? last_strb : 4'hF, last, last ? user : 1'b0, w);
            stalls += w;
        end
        RvviAxiRvalid = 1'b0;
        RvviAxiRlast  = 1'b0;
        RvviAxiRuser  = 1'b0;
    endtask

    // Good frame with ready high: valid one cycle after tlast, then consumed on the next edge.
    task automatic good_frame(input string tag, input logic [47:0] dst, input logic [15:0] seq,
                              input int seed, input logic [3:0] last_strb, input logic exp_err);
        int st;
        send_frame(dst, ETYPE, seq, seed, PW, last_strb, 1'b0, -1, 1'b1, st);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_seqerr"}, 32'(SeqError), 32'(exp_err));
        @(negedge clk);
        exp_frames++;
        check({tag, "_frames"}, FrameCount, 32'(exp_frames));
        check({tag, "_seqerr_pulse"}, 32'(SeqError), 32'd0);
        check({tag, "_valid_clear"}, 32'(valid), 32'd0);
    endtask

    task automatic drop_frame(input string tag, input logic [47:0] dst, input logic [15:0] etype,
                              input int n_pay, input logic [3:0] last_strb, input logic user);
        int st;
        send_frame(dst, etype, 16'h0BAD, 77, n_pay, last_strb, user, -1, 1'b0, st);
        exp_drops++;
        check({tag, "_drops"}, DropCount, 32'(exp_drops));
        check({tag, "_no_valid"}, 32'(valid), 32'd0);
        check({tag, "_stalls"}, 32'(st), 32'd0);
    endtask

    initial begin
        int st;
        rst_n         = 1'b0;
        RvviAxiRdata  = '0;
        RvviAxiRstrb  = '0;
        RvviAxiRvalid = 1'b0;
        RvviAxiRlast  = 1'b0;
        RvviAxiRuser  = 1'b0;
        ready         = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        good_frame("good_seq0", MAC, 16'd0, 3, 4'hF, 1'b0);

        drop_frame("etype_0800", MAC, 16'h0800, PW, 4'hF, 1'b0);
        good_frame("after_etype", MAC, 16'd1, 5, 4'hF, 1'b0);

        drop_frame("runt", MAC, ETYPE, 11, 4'hF, 1'b0);
        good_frame("after_runt", MAC, 16'd2, 7, 4'hF, 1'b0);

        // Back-pressure: second frame waits while the first is held.
        ready = 1'b0;
        send_frame(MAC, ETYPE, 16'd3, 9, PW, 4'hF, 1'b0, -1, 1'b1, st);
        check("hold_valid", 32'(valid), 32'd1);
        fork
            begin
                int st2;
                send_frame(MAC, ETYPE, 16'd4, 10, PW, 4'hF, 1'b0, -1, 1'b1, st2);
            end
            begin
                repeat (50) @(negedge clk);
                check("hold_rx_ready", 32'(RvviAxiRready), 32'd0);
                check("hold_still_valid", 32'(valid), 32'd1);
                check("hold_frames", FrameCount, 32'(exp_frames));
                ready = 1'b1;
            end
        join
        check("bp_second_valid", 32'(valid), 32'd1);
        @(negedge clk);
        exp_frames += 2;
        check("bp_frames", FrameCount, 32'(exp_frames));

        good_frame("bcast_partial", BCAST, 16'd5, 11, 4'h7, 1'b0);
        drop_frame("short_keep", MAC, ETYPE, PW, 4'h3, 1'b0);
        drop_frame("oversize", MAC, ETYPE, PW + 1, 4'hF, 1'b0);
        drop_frame("wrong_dst", 48'h1654_1111_6844, ETYPE, PW, 4'hF, 1'b0);

        good_frame("seq6", MAC, 16'd6, 13, 4'hF, 1'b0);
        good_frame("seq8_gap", MAC, 16'd8, 14, 4'hF, 1'b1);
        good_frame("seq9", MAC, 16'd9, 15, 4'hF, 1'b0);

        drop_frame("user_bad", MAC, ETYPE, PW, 4'hF, 1'b1);

        // Reset at payload beat 12; the remaining beats fail as a header.
        send_frame(MAC, ETYPE, 16'd10, 17, PW, 4'hF, 1'b0, 4 + 12, 1'b0, st);
        exp_frames = 0;
        exp_drops  = 1;
        check("post_reset_drops", DropCount, 32'(exp_drops));
        check("post_reset_valid", 32'(valid), 32'd0);
        good_frame("first_after_reset", MAC, 16'd100, 19, 4'hF, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
